// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one burst at a time from a synchronous single-port SRAM.
// Reads take two cycles per beat (request, then data); writes go straight to the SRAM
// on each accepted W beat. Responses are always OKAY.
module axi_sram_slave #(
  parameter int unsigned ADDR_W     = 16,
  parameter bit          READ_FIRST = 1'b1
) (
  input  logic              aclk_i,
  input  logic              aresetn_i,
  // read address
  input  logic [3:0]        arid_i,
  input  logic [31:0]       araddr_i,
  input  logic [7:0]        arlen_i,
  input  logic [2:0]        arsize_i,
  input  logic [1:0]        arburst_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  // read data
  output logic [3:0]        rid_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  // write address
  input  logic [3:0]        awid_i,
  input  logic [31:0]       awaddr_i,
  input  logic [7:0]        awlen_i,
  input  logic [2:0]        awsize_i,
  input  logic [1:0]        awburst_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  // write data
  input  logic [3:0]        wid_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wlast_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  // write response
  output logic [3:0]        bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  // SRAM
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_R_REQ  = 3'd1;
  localparam logic [2:0] ST_R_DATA = 3'd2;
  localparam logic [2:0] ST_W_DATA = 3'd3;
  localparam logic [2:0] ST_B_RESP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [31:0] rdata_q;
  logic        rd_first_q;

  logic        st_idle;
  logic        ar_hs;
  logic        aw_hs;
  logic        w_beat;
  logic        beat_last;
  logic [31:0] addr_next;

  // Beat ordering is counted locally; the master's wlast and wid carry no information here.
  logic unused_w;
  assign unused_w = ^{wid_i, wlast_i};

  assign st_idle   = (state_q == ST_IDLE);
  // Readies are gated by reset so that every handshake output reads 0 while reset is held.
  assign arready_o = aresetn_i & st_idle & (READ_FIRST | ~awvalid_i);
  assign awready_o = aresetn_i & st_idle & (~READ_FIRST | ~arvalid_i);
  assign ar_hs     = arvalid_i & arready_o;
  assign aw_hs     = awvalid_i & awready_o;
  assign w_beat    = (state_q == ST_W_DATA) & wvalid_i;
  assign beat_last = (cnt_q == len_q);
  // FIXED holds the address; INCR, WRAP and reserved encodings all step by the beat size.
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_d = ST_R_REQ;
          id_d    = arid_i;
          addr_d  = araddr_i;
          len_d   = arlen_i;
          size_d  = arsize_i;
          burst_d = arburst_i;
          cnt_d   = 8'd0;
        end else if (aw_hs) begin
          state_d = ST_W_DATA;
          id_d    = awid_i;
          addr_d  = awaddr_i;
          len_d   = awlen_i;
          size_d  = awsize_i;
          burst_d = awburst_i;
          cnt_d   = 8'd0;
        end
      end
      ST_R_REQ: state_d = ST_R_DATA;
      ST_R_DATA: begin
        if (rready_i) begin
          if (beat_last) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_R_REQ;
            cnt_d   = cnt_q + 8'd1;
            addr_d  = addr_next;
          end
        end
      end
      ST_W_DATA: begin
        if (wvalid_i) begin
          if (beat_last) begin
            state_d = ST_B_RESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_next;
          end
        end
      end
      ST_B_RESP: begin
        if (bready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and burst state registers.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= ST_IDLE;
      id_q    <= 4'd0;
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'b00;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
    end
  end

  // Capture SRAM data in the first R_DATA cycle so it holds while rready is low.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rd_first_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      rd_first_q <= (state_q == ST_R_REQ);
      if (rd_first_q) rdata_q <= ram_rdata_i;
    end
  end

  // The SRAM output is only valid in the first data cycle, so pass it through there.
  assign rdata_o     = rd_first_q ? ram_rdata_i : rdata_q;
  assign rvalid_o    = (state_q == ST_R_DATA);
  assign rlast_o     = rvalid_o & beat_last;
  assign rid_o       = id_q;
  assign rresp_o     = 2'b00;
  assign wready_o    = (state_q == ST_W_DATA);
  assign bvalid_o    = (state_q == ST_B_RESP);
  assign bid_o       = id_q;
  assign bresp_o     = 2'b00;
  assign ram_en_o    = (state_q == ST_R_REQ) | w_beat;
  assign ram_we_o    = w_beat ? wstrb_i : 4'b0000;
  assign ram_addr_o  = addr_q[ADDR_W+1:2];
  assign ram_wdata_o = w_beat ? wdata_i : 32'd0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: SRAM model, scoreboard queues, vector table, corner sequences.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata, ram_wdata, ram_rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  wstrb, ram_we;
  logic [15:0] ram_addr;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready;
  logic bvalid, bready, ram_en;

  // second instance, write-priority, own handshake inputs
  logic b_arvalid, b_awvalid, b_wvalid, b_rready, b_bready;
  logic b_arready, b_awready, b_wready, b_rvalid, b_rlast, b_bvalid, b_ram_en;
  logic [3:0]  b_rid, b_bid, b_ram_we;
  logic [31:0] b_rdata, b_ram_wdata;
  logic [1:0]  b_rresp, b_bresp;
  logic [15:0] b_ram_addr;

  axi_sram_slave #(.ADDR_W(16), .READ_FIRST(1'b1)) u_dut (
    .aclk_i(clk), .aresetn_i(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
    .rready_i(rready),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid),
    .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  axi_sram_slave #(.ADDR_W(16), .READ_FIRST(1'b0)) u_dut_wf (
    .aclk_i(clk), .aresetn_i(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arvalid_i(b_arvalid), .arready_o(b_arready),
    .rid_o(b_rid), .rdata_o(b_rdata), .rresp_o(b_rresp), .rlast_o(b_rlast), .rvalid_o(b_rvalid),
    .rready_i(b_rready),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(b_awvalid), .awready_o(b_awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(b_wvalid),
    .wready_o(b_wready),
    .bid_o(b_bid), .bresp_o(b_bresp), .bvalid_o(b_bvalid), .bready_i(b_bready),
    .ram_en_o(b_ram_en), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(32'h0)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no/unexpected event want expected handshake", nm);
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return {16'(i) ^ 16'h1234, 16'(i)};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // SRAM model: one-cycle registered read, byte-enabled write
  logic [31:0] mem [65536];
  logic        load_mem;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
    end else if (ram_en) begin
      if (ram_we == 4'b0) ram_rdata <= mem[ram_addr];
      else mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_we);
    end
  end

  // scoreboard
  typedef struct { logic [15:0] word; logic [3:0] we; logic [31:0] data; } wexp_t;
  typedef struct { logic [31:0] data; logic last; logic [3:0] id; } rexp_t;
  wexp_t       wq[$];
  rexp_t       rq[$];
  logic [15:0] raq[$];
  logic [31:0] ref_mem [65536];

  logic [15:0] last_word;
  logic        held, held_last;
  logic [31:0] held_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en) begin
        last_word <= ram_addr;
        if (ram_we == 4'b0) begin
          if (raq.size() == 0) flag("ram_read_extra");
          else chk("ram_raddr", 32'(ram_addr), 32'(raq.pop_front()));
        end else begin
          if (wq.size() == 0) flag("ram_write_extra");
          else begin
            chk("ram_waddr", 32'(ram_addr), 32'(wq[0].word));
            chk("ram_we", 32'(ram_we), 32'(wq[0].we));
            chk("ram_wdata", ram_wdata, wq[0].data);
            void'(wq.pop_front());
          end
        end
      end
      if (rvalid) begin
        if (held) begin
          chk("r_hold_data", rdata, held_data);
          chk("r_hold_last", 32'(rlast), 32'(held_last));
        end
        held      <= !rready;
        held_data <= rdata;
        held_last <= rlast;
      end else begin
        held <= 1'b0;
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) flag("r_beat_extra");
        else begin
          chk("rdata", rdata, rq[0].data);
          chk("rlast", 32'(rlast), 32'(rq[0].last));
          chk("rid", 32'(rid), 32'(rq[0].id));
          chk("rresp", 32'(rresp), 0);
          void'(rq.pop_front());
        end
      end
    end else begin
      held <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      raq.push_back(a[17:2]);
      rq.push_back('{data: ref_mem[a[17:2]], last: (i == len), id: id});
      if (burst != 2'b00) a = a + (32'd1 << size);
    end
  endtask

  task automatic ar_hs;
    int n;
    n = 0;
    arvalid = 1'b1;
    #1;
    while (!arready && n < 100) begin tick(); n++; end
    if (!arready) flag("ar_timeout");
    tick();
    arvalid = 1'b0;
  endtask

  task automatic aw_hs;
    int n;
    n = 0;
    awvalid = 1'b1;
    #1;
    while (!awready && n < 100) begin tick(); n++; end
    if (!awready) flag("aw_timeout");
    tick();
    awvalid = 1'b0;
  endtask

  task automatic rd_data(input int len, input int stall_beat, input int stall_n);
    for (int i = 0; i <= len; i++) begin
      int n;
      n = 0;
      rready = 1'b0;
      while (!rvalid && n < 100) begin tick(); n++; end
      if (!rvalid) flag("r_timeout");
      if (i == stall_beat) repeat (stall_n) tick();
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  task automatic wr_data(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [3:0] strb0, input logic [3:0] strb, input int gap);
    logic [31:0] a;
    int n;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      if (i > 0 && gap > 0) begin
        wvalid = 1'b0;
        repeat (gap) tick();
      end
      wdata = $urandom;
      wstrb = (i == 0) ? strb0 : strb;
      wq.push_back('{word: a[17:2], we: wstrb, data: wdata});
      ref_mem[a[17:2]] = merge(ref_mem[a[17:2]], wdata, wstrb);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin tick(); n++; end
      if (!wready) flag("w_timeout");
      tick();
      if (burst != 2'b00) a = a + (32'd1 << size);
    end
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 100) begin tick(); n++; end
    chk("bvalid", 32'(bvalid), 1);
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid), 0);
  endtask

  typedef struct {
    bit wr; logic [3:0] id; logic [31:0] addr; int len; logic [2:0] size; logic [1:0] burst;
    logic [3:0] strb0; logic [3:0] strb; int gap; int stall_beat; int stall_n;
    logic [15:0] exp_last;
  } vec_t;
  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    vecs[0]  = '{0, 4'h3, 32'h10,    0,  3'd2, 2'b01, 4'hF, 4'hF, 0, -1, 0, 16'h0004};
    vecs[1]  = '{0, 4'h5, 32'h0,     3,  3'd2, 2'b01, 4'hF, 4'hF, 0,  1, 3, 16'h0003};
    vecs[2]  = '{1, 4'h2, 32'h8,     1,  3'd2, 2'b01, 4'h3, 4'hF, 2, -1, 0, 16'h0003};
    vecs[3]  = '{0, 4'h6, 32'h8,     1,  3'd2, 2'b01, 4'hF, 4'hF, 0, -1, 0, 16'h0003};
    vecs[4]  = '{1, 4'h1, 32'h40,    2,  3'd2, 2'b00, 4'hF, 4'hF, 0, -1, 0, 16'h0010};
    vecs[5]  = '{0, 4'h4, 32'h40,    1,  3'd2, 2'b00, 4'hF, 4'hF, 0, -1, 0, 16'h0010};
    vecs[6]  = '{1, 4'h8, 32'h3FFFC, 1,  3'd2, 2'b01, 4'hF, 4'hF, 0, -1, 0, 16'h0000};
    vecs[7]  = '{0, 4'h9, 32'h3FFFC, 1,  3'd2, 2'b01, 4'hF, 4'hF, 0, -1, 0, 16'h0000};
    vecs[8]  = '{1, 4'hC, 32'h20,    3,  3'd0, 2'b01, 4'h1, 4'h1, 0, -1, 0, 16'h0008};
    vecs[9]  = '{0, 4'hF, 32'h1000,  15, 3'd2, 2'b01, 4'hF, 4'hF, 0, 15, 2, 16'h040F};
    vecs[10] = '{0, 4'h7, 32'h100,   2,  3'd2, 2'b10, 4'hF, 4'hF, 0, -1, 0, 16'h0042};

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0; load_mem = 1'b1;
    {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
    {awid, awaddr, awlen, awsize, awburst, awvalid, wid, wdata, wstrb, wlast, wvalid, bready} = '0;
    {b_arvalid, b_awvalid, b_wvalid, b_rready, b_bready} = '0;
    repeat (3) tick();
    chk("init_ready", 32'({arready, awready, wready}), 0);
    chk("init_valid", 32'({rvalid, bvalid, rlast}), 0);
    chk("init_ram", 32'({ram_en, ram_we}), 0);
    chk("init_ids", 32'({rid, bid}), 0);
    chk("init_rdata", rdata, 0);
    load_mem = 1'b0;
    rst_n = 1'b1;
    tick();

    // single-beat read latency: address at T+1, data at T+2
    arid = 4'h7; araddr = 32'h10; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    push_read(4'h7, 32'h10, 0, 3'd2, 2'b01);
    arvalid = 1'b1;
    #1;
    chk("t1_arready", 32'(arready), 1);
    tick();
    arvalid = 1'b0;
    chk("t1_ram_en", 32'(ram_en), 1);
    chk("t1_ram_addr", 32'(ram_addr), 32'h4);
    chk("t1_rvalid_early", 32'(rvalid), 0);
    tick();
    chk("t1_rvalid", 32'(rvalid), 1);
    chk("t1_rlast", 32'(rlast), 1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_rid", 32'(rid), 32'h7);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("t1_rvalid_drop", 32'(rvalid), 0);

    for (int v = 0; v < 11; v++) begin
      arid = vecs[v].id; araddr = vecs[v].addr; arlen = 8'(vecs[v].len);
      arsize = vecs[v].size; arburst = vecs[v].burst;
      awid = vecs[v].id; awaddr = vecs[v].addr; awlen = 8'(vecs[v].len);
      awsize = vecs[v].size; awburst = vecs[v].burst;
      if (vecs[v].wr) begin
        aw_hs();
        wr_data(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                vecs[v].strb0, vecs[v].strb, vecs[v].gap);
      end else begin
        push_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
        ar_hs();
        rd_data(vecs[v].len, vecs[v].stall_beat, vecs[v].stall_n);
      end
      chk($sformatf("vec%0d_last_word", v), 32'(last_word), 32'(vecs[v].exp_last));
    end

    // AR and AW together: read first, write waits for the end of the read
    arid = 4'h9; araddr = 32'h0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    awid = 4'hA; awaddr = 32'h80; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    push_read(4'h9, 32'h0, 0, 3'd2, 2'b01);
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    chk("rf_arready", 32'(arready), 1);
    chk("rf_awready", 32'(awready), 0);
    tick();
    arvalid = 1'b0;
    chk("rf_aw_wait", 32'(awready), 0);
    rd_data(0, -1, 0);
    chk("rf_aw_after_read", 32'(awready), 1);
    aw_hs();
    wr_data(4'hA, 32'h80, 0, 3'd2, 2'b01, 4'hF, 4'hF, 0);

    // reset in the middle of an 8-beat write
    awid = 4'h3; awaddr = 32'h400; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01;
    aw_hs();
    chk("abort_wready", 32'(wready), 1);
    a = 32'h400;
    for (int i = 0; i < 3; i++) begin
      wdata = $urandom; wstrb = 4'hF;
      wq.push_back('{word: a[17:2], we: wstrb, data: wdata});
      wvalid = 1'b1;
      a = a + 32'd4;
      if (i < 2) tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'({arready, awready, wready}), 0);
    chk("rst_valid", 32'({rvalid, bvalid, rlast}), 0);
    chk("rst_ram", 32'({ram_en, ram_we}), 0);
    chk("rst_ids", 32'({rid, bid}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wdata", ram_wdata, 0);
    wvalid = 1'b0;
    wq.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    arid = 4'h1; araddr = 32'h10; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    push_read(4'h1, 32'h10, 0, 3'd2, 2'b01);
    ar_hs();
    rd_data(0, -1, 0);
    chk("post_rst_last_word", 32'(last_word), 32'h4);

    // write-priority instance: AW wins, AR waits for the B response
    awid = 4'hB; awaddr = 32'h200; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    arid = 4'hC; araddr = 32'h204; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    wdata = 32'hCAFEF00D; wstrb = 4'hF;
    b_arvalid = 1'b1; b_awvalid = 1'b1;
    #1;
    chk("wf_arready", 32'(b_arready), 0);
    chk("wf_awready", 32'(b_awready), 1);
    tick();
    b_awvalid = 1'b0;
    chk("wf_wready", 32'(b_wready), 1);
    chk("wf_ar_wait", 32'(b_arready), 0);
    b_wvalid = 1'b1;
    #1;
    chk("wf_ram_we", 32'(b_ram_we), 32'hF);
    chk("wf_ram_addr", 32'(b_ram_addr), 32'h80);
    chk("wf_ram_wdata", b_ram_wdata, 32'hCAFEF00D);
    tick();
    b_wvalid = 1'b0;
    chk("wf_bvalid", 32'(b_bvalid), 1);
    chk("wf_bid", 32'(b_bid), 32'hB);
    chk("wf_ar_wait_b", 32'(b_arready), 0);
    b_bready = 1'b1;
    tick();
    b_bready = 1'b0;
    chk("wf_arready_idle", 32'(b_arready), 1);
    tick();
    b_arvalid = 1'b0;
    chk("wf_r_req", 32'({b_ram_en, b_ram_we}), 32'h10);
    chk("wf_r_addr", 32'(b_ram_addr), 32'h81);
    tick();
    chk("wf_rvalid", 32'({b_rvalid, b_rlast}), 32'h3);
    chk("wf_rid", 32'(b_rid), 32'hC);
    chk("wf_rdata", b_rdata, 0);
    chk("wf_resp", 32'({b_rresp, b_bresp}), 0);
    b_rready = 1'b1;
    tick();
    b_rready = 1'b0;
    chk("wf_rvalid_drop", 32'(b_rvalid), 0);

    tick(); tick();
    chk("rq_empty", 32'(rq.size()), 0);
    chk("raq_empty", 32'(raq.size()), 0);
    chk("wq_empty", 32'(wq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
